// File: rtl/tremolo_pkg.sv
// Shared types and constants for the tremolo stage.
// Holds the FSM state encoding, gain format and the LFO clamp helper.
package tremolo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        MUL  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int GAIN_W     = 6;
    localparam int GAIN_SHIFT = 5;
    localparam int DEPTH_MAX  = 16;

    function automatic logic signed [31:0] clamp_lfo(input logic signed [31:0] v, input int amp);
        logic signed [31:0] r;
        if (v > amp) begin
            r = amp;
        end else if (v < -amp) begin
            r = -amp;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/tremolo_modulator_if.sv
// Sample-stream handshake bundle: input samples in, modulated samples out.
// master drives in_sample/in_valid/out_ready; slave is the modulator side.
interface tremolo_modulator_if #(
    parameter int SAMPLE_W = 16
);
    logic signed [SAMPLE_W-1:0] in_sample;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [SAMPLE_W-1:0] out_sample;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output in_sample, in_valid, out_ready,
        input  in_ready, out_sample, out_valid
    );

    modport slave (
        input  in_sample, in_valid, out_ready,
        output in_ready, out_sample, out_valid
    );
endinterface

// File: rtl/tremolo_gain_calc.sv
// Purpose: combinational LFO/depth -> gain (0..32, unity at 32).
// Latency: none (parent registers the result). Backpressure: n/a.
module tremolo_gain_calc
    import tremolo_pkg::*;
#(
    parameter int LFO_W   = 32,
    parameter int LFO_AMP = 16
) (
    input  logic signed [LFO_W-1:0] lfo_s,
    input  logic [4:0]              depth,
    output logic [GAIN_W-1:0]       gain
);

    logic signed [31:0] m;
    logic [4:0]         d;
    logic [5:0]         span;
    logic [9:0]         prod;

    always_comb begin
        m    = clamp_lfo(32'(lfo_s), LFO_AMP);
        d    = (depth > 5'(DEPTH_MAX)) ? 5'(DEPTH_MAX) : depth;
        // 16 - m spans 0..32 for the nominal +/-16 LFO swing
        span = 6'(32'sd16 - m);
        prod = 10'(d) * 10'(span);
        gain = 6'd32 - 6'(prod >> 4);
    end

endmodule

// File: rtl/tremolo_modulator.sv
// Purpose: tremolo gain stage; optional TREMOLO_ROUND_EN selects round-half-up + saturate.
// Latency: accept at cycle N -> out_valid at N+3; one sample in flight (1 per 4 cycles max).
// Backpressure: out_ready low parks the result in HOLD, in_ready stays low until drained.
module tremolo_modulator
    import tremolo_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int LFO_W       = 32,
    parameter int LFO_AMP     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic signed [LFO_W-1:0] lfo,
    input  logic [4:0]              depth,
    tremolo_modulator_if.slave      bus
);

    localparam int PW = SAMPLE_W + 7;
    localparam logic signed [PW-1:0] RND     = PW'(16);
    localparam logic signed [PW-1:0] SAT_MAX = PW'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

    state_t                     state_q, state_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic [GAIN_W-1:0]          gain_q, gain_d;
    logic signed [SAMPLE_W-1:0] out_sample_q, out_sample_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [LFO_W-1:0]    lfo_sync_q [SYNC_STAGES];
    logic signed [LFO_W-1:0]    lfo_sync_d [SYNC_STAGES];

    logic [GAIN_W-1:0]          gain_w;
    logic signed [PW-1:0]       prod;
    logic signed [PW-1:0]       scaled;
    logic signed [SAMPLE_W-1:0] mul_res;

    // lfo originates in a divided-clock domain; only the last stage feeds the gain
    always_comb begin
        lfo_sync_d[0] = lfo;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            lfo_sync_d[i] = lfo_sync_q[i-1];
        end
    end

    tremolo_gain_calc #(
        .LFO_W   (LFO_W),
        .LFO_AMP (LFO_AMP)
    ) u_gain_calc (
        .lfo_s (lfo_sync_q[SYNC_STAGES-1]),
        .depth (depth),
        .gain  (gain_w)
    );

    always_comb begin
        prod = PW'(sample_q) * PW'($signed({1'b0, gain_q}));
`ifdef TREMOLO_ROUND_EN
        scaled = (prod + RND) >>> GAIN_SHIFT;
        if (scaled > SAT_MAX) begin
            mul_res = SAMPLE_W'(SAT_MAX);
        end else if (scaled < SAT_MIN) begin
            mul_res = SAMPLE_W'(SAT_MIN);
        end else begin
            mul_res = SAMPLE_W'(scaled);
        end
`else
        // gain <= 32 keeps the floored result inside SAMPLE_W
        scaled  = prod >>> GAIN_SHIFT;
        mul_res = SAMPLE_W'(scaled);
`endif
    end

    always_comb begin
        state_d      = state_q;
        sample_d     = sample_q;
        gain_d       = gain_q;
        out_sample_d = out_sample_q;
        out_valid_d  = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sample_d = bus.in_sample;
                    state_d  = CALC;
                end
            end
            CALC: begin
                gain_d  = gain_w;
                state_d = MUL;
            end
            MUL: begin
                out_sample_d = mul_res;
                out_valid_d  = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            sample_q     <= '0;
            gain_q       <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                lfo_sync_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            sample_q     <= sample_d;
            gain_q       <= gain_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                lfo_sync_q[i] <= lfo_sync_d[i];
            end
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_sample = out_sample_q;
    assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_tremolo_modulator.sv
// Bench for tremolo_modulator: directed scenarios plus randomized samples
// compared against an integer-arithmetic model of the gain/scale rules.
module tb_tremolo_modulator;

    logic               CLK;
    logic               RESET_N;
    logic signed [31:0] lfo_i;
    logic [4:0]         depth_i;

    int n_checks;
    int n_pass;

    tremolo_modulator_if #(.SAMPLE_W(16)) bus();

    tremolo_modulator #(
        .SAMPLE_W    (16),
        .LFO_W       (32),
        .LFO_AMP     (16),
        .SYNC_STAGES (2)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .lfo     (lfo_i),
        .depth   (depth_i),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Integer reference: floor/round computed with division, not shifts
    function automatic int model(input int s, input int lv, input int dv);
        int m, d, g, p, r;
        m = (lv > 16) ? 16 : ((lv < -16) ? -16 : lv);
        d = (dv > 16) ? 16 : dv;
        g = 32 - (d * (16 - m)) / 16;
        p = s * g;
`ifdef TREMOLO_ROUND_EN
        p = p + 16;
`endif
        r = (p >= 0) ? (p / 32) : -((-p + 31) / 32);
`ifdef TREMOLO_ROUND_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one sample with out_ready held high; lat = 99 on timeout
    task automatic send(input int s, input int lv, input int dv, output int got, output int lat);
        int w;
        lfo_i         = lv;
        depth_i       = 5'(dv);
        bus.out_ready = 1'b1;
        repeat (4) tick();
        bus.in_sample = 16'(s);
        bus.in_valid  = 1'b1;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        tick();
        bus.in_valid = 1'b0;
        w = 0;
        while (bus.out_valid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        lat = (bus.out_valid === 1'b1) ? w + 1 : 99;
        got = bus.out_sample;
        tick();
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        #3;
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        else n_pass++;
        n_checks++;
        if (bus.out_sample !== 16'sd0) $display("FAIL reset_out_sample got=%0d exp=0", bus.out_sample);
        else n_pass++;
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_unity();
        int got, lat;
        send(1000, -16, 0, got, lat);
        n_checks++;
        if (got !== 1000) $display("FAIL unity_value got=%0d exp=1000", got);
        else n_pass++;
        n_checks++;
        if (lat !== 3) $display("FAIL unity_latency got=%0d exp=3", lat);
        else n_pass++;
    endtask

    task automatic test_depth();
        int lv [6] = '{-16, 0, 16, -16, 0, -16};
        int dv [6] = '{16, 16, 16, 8, 31, 31};
        int ev [6] = '{0, 500, 1000, 500, 500, 0};
        int got, lat;
        for (int i = 0; i < 6; i++) begin
            send(1000, lv[i], dv[i], got, lat);
            n_checks++;
            if (got !== ev[i]) $display("FAIL depth_%0d got=%0d exp=%0d (lfo=%0d depth=%0d)", i, got, ev[i], lv[i], dv[i]);
            else n_pass++;
        end
    endtask

    task automatic test_clamp();
        int got, lat;
        send(-2000, 40, 16, got, lat);
        n_checks++;
        if (got !== -2000) $display("FAIL clamp_pos got=%0d exp=-2000", got);
        else n_pass++;
        send(-2000, -100, 16, got, lat);
        n_checks++;
        if (got !== 0) $display("FAIL clamp_neg got=%0d exp=0", got);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int w;
        lfo_i         = 0;
        depth_i       = 5'd16;
        bus.out_ready = 1'b0;
        repeat (4) tick();
        bus.in_sample = 16'sd1200;
        bus.in_valid  = 1'b1;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        tick();
        bus.in_sample = -16'sd600;
        w = 0;
        while (bus.out_valid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_checks++;
        if (bus.out_sample !== 16'sd600) $display("FAIL bp_first got=%0d exp=600", bus.out_sample);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus.out_sample !== 16'sd600 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                $display("FAIL bp_hold_%0d got sample=%0d valid=%b ready=%b exp 600/1/0",
                         i, bus.out_sample, bus.out_valid, bus.in_ready);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL bp_release got ready=%b valid=%b exp 1/0", bus.in_ready, bus.out_valid);
        else n_pass++;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_second_accept got ready=%b exp=0", bus.in_ready);
        else n_pass++;
        w = 0;
        while (bus.out_valid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        n_checks++;
        if (bus.out_sample !== -16'sd300 || bus.out_valid !== 1'b1)
            $display("FAIL bp_second got=%0d valid=%b exp=-300/1", bus.out_sample, bus.out_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_rounding();
        int got, lat;
        int exp_p, exp_n;
`ifdef TREMOLO_ROUND_EN
        exp_p = 2;
        exp_n = -1;
`else
        exp_p = 1;
        exp_n = -2;
`endif
        send(3, 0, 16, got, lat);
        n_checks++;
        if (got !== exp_p) $display("FAIL round_pos got=%0d exp=%0d", got, exp_p);
        else n_pass++;
        send(-3, 0, 16, got, lat);
        n_checks++;
        if (got !== exp_n) $display("FAIL round_neg got=%0d exp=%0d", got, exp_n);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        int w, got, lat;
        lfo_i         = 0;
        depth_i       = 5'd0;
        bus.out_ready = 1'b1;
        repeat (4) tick();
        bus.in_sample = 16'sd1000;
        bus.in_valid  = 1'b1;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        tick();
        bus.in_valid = 1'b0;
        tick();
        RESET_N = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sample !== 16'sd0)
            $display("FAIL rst_mul got ready=%b valid=%b sample=%0d exp 1/0/0",
                     bus.in_ready, bus.out_valid, bus.out_sample);
        else n_pass++;
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        repeat (4) tick();
        bus.in_sample = 16'sd1000;
        bus.in_valid  = 1'b1;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        tick();
        bus.in_valid = 1'b0;
        w = 0;
        while (bus.out_valid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        tick();
        RESET_N = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sample !== 16'sd0)
            $display("FAIL rst_hold got ready=%b valid=%b sample=%0d exp 1/0/0",
                     bus.in_ready, bus.out_valid, bus.out_sample);
        else n_pass++;
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        send(1000, -16, 0, got, lat);
        n_checks++;
        if (got !== 1000 || lat !== 3) $display("FAIL rst_recover got=%0d lat=%0d exp=1000 lat=3", got, lat);
        else n_pass++;
    endtask

    task automatic test_random();
        int s, lv, dv, exp_v, got, lat;
        for (int i = 0; i < 30; i++) begin
            s  = int'($urandom_range(65535)) - 32768;
            lv = int'($urandom_range(80)) - 40;
            dv = int'($urandom_range(31));
            if (i == 0) s = -32768;
            if (i == 1) s = 32767;
            exp_v = model(s, lv, dv);
            send(s, lv, dv, got, lat);
            n_checks++;
            if (got !== exp_v || lat !== 3)
                $display("FAIL rand_%0d got=%0d lat=%0d exp=%0d lat=3 (s=%0d lfo=%0d depth=%0d)",
                         i, got, lat, exp_v, s, lv, dv);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        lfo_i         = 0;
        depth_i       = 5'd0;
        bus.in_sample = 16'sd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_unity();
        test_depth();
        test_clamp();
        test_backpressure();
        test_rounding();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
